// File: rtl/fm_matrix_pkg.sv
// Shared types and helpers for the matrix tile loader and the read sequencer.
package fm_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ldr_state_t;

  // True when (row, col) is the bottom-right cell of a rowwidth x colwidth tile.
  function automatic logic is_last_cell(input int row, input int col,
                                        input int rowwidth, input int colwidth);
    return (row == rowwidth - 1) && (col == colwidth - 1);
  endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row-major cell counter for a ROWWIDTH x COLWIDTH tile.
// Column advances on every inc; on the last column it wraps and the row advances.
// After the final cell both fields wrap to zero, so neither ever leaves its range.
module matrix_rc_counter
  import fm_matrix_pkg::*;
#(
  parameter int ROWWIDTH = 4,
  parameter int COLWIDTH = 4,
  localparam int RW = (ROWWIDTH > 1) ? $clog2(ROWWIDTH) : 1,
  localparam int CW = (COLWIDTH > 1) ? $clog2(COLWIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  assign last = is_last_cell(int'(row), int'(col), ROWWIDTH, COLWIDTH);

  // Clear has priority over increment; increment walks the tile row-major.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == CW'(COLWIDTH - 1)) begin
        col <= '0;
        if (row == RW'(ROWWIDTH - 1)) row <= '0;
        else                          row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_tile_loader.sv
// Write-side feeder for the packed per-lane register file: takes a row-major
// element stream and writes one tile, replicating every element to each lane
// enabled in the bank mask captured at start.
//
// Handshake: an element transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the state register (high in LOAD), so
// there is no combinational path from in_valid to in_ready. The upstream holds
// in_data/in_last stable while in_valid is high and in_ready is low.
module matrix_tile_loader
  import fm_matrix_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ROWWIDTH = 4,
  parameter int COLWIDTH = 4,
  parameter int NUMREADS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:NUMREADS-1] bank_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic                in_last,
  output logic                busy,
  output logic                done,
  output logic                len_err,
  output logic [0:NUMREADS-1] wren,
  output logic [31:0]         row_wr_addr [0:NUMREADS-1],
  output logic [31:0]         col_wr_addr [0:NUMREADS-1],
  output logic [DW-1:0]       wr_data     [0:NUMREADS-1],
  output logic [1:0]          dbg_state
);

  localparam int RW = (ROWWIDTH > 1) ? $clog2(ROWWIDTH) : 1;
  localparam int CW = (COLWIDTH > 1) ? $clog2(COLWIDTH) : 1;

  ldr_state_t          state;
  logic [0:NUMREADS-1] mask_q;
  logic                beat;
  logic                cnt_clr;
  logic                cell_last;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;

  assign in_ready  = (state == LOAD);
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign beat      = in_valid & in_ready;
  assign cnt_clr   = (state == IDLE) & start;

  matrix_rc_counter #(
    .ROWWIDTH (ROWWIDTH),
    .COLWIDTH (COLWIDTH)
  ) u_rc (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (beat),
    .row  (row),
    .col  (col),
    .last (cell_last)
  );

  // Load sequencing: latch mask on start, end the tile on the final cell or on
  // in_last, and flag any disagreement between the two as a length error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask_q  <= '0;
      len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= bank_mask;
            len_err <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (beat && (cell_last || in_last)) begin
            state <= DONE;
            if (cell_last != in_last) len_err <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobes: one cycle after each beat, enabled lanes get a write pulse.
  always_ff @(posedge clk) begin
    if (rst) wren <= '0;
    else     wren <= mask_q & {NUMREADS{beat}};
  end

  // Per-lane address/data copies; they hold their last value between beats.
  for (genvar i = 0; i < NUMREADS; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        row_wr_addr[i] <= '0;
        col_wr_addr[i] <= '0;
        wr_data[i]     <= '0;
      end else if (beat) begin
        row_wr_addr[i] <= 32'(row);
        col_wr_addr[i] <= 32'(col);
        wr_data[i]     <= in_data;
      end
    end
  end

endmodule
